// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter that shares one APB master port between NREQ requesters.
// Each granted request runs a single SETUP/ACCESS transfer. The response is returned to the winning requester.
//
// state  | meaning
// S_IDLE | arbitrate; req_ready shows the combinational winner
// S_SETUP| first APB phase: psel asserted, penable low
// S_ACCESS| penable high; wait for pready or the timeout
module apb_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               pclk,
  input  logic               preset,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*32-1:0] req_addr,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*32-1:0] req_wdata,
  input  logic [NREQ*4-1:0]  req_strb,
  input  logic [NREQ*3-1:0]  req_prot,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  output logic [31:0]        paddr,
  output logic [3:0]         psel,
  output logic               penable,
  output logic               pwrite,
  output logic [31:0]        pwdata,
  output logic [3:0]         pstrb,
  output logic [2:0]         pprot,
  input  logic [31:0]        prdata,
  input  logic               pready,
  input  logic               pslverr
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t         state, state_nxt;
  logic [IW-1:0]  ptr;
  logic [IW-1:0]  win_idx;
  logic           win_found;
  logic [TW-1:0]  tcnt;
  logic           tmo;
  logic           done;

  // Search starts just past the last winner, so the last winner gets the lowest priority.
  always_comb begin : rr_pick
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = IW'(idx);
      end
    end
  end

  assign tmo  = (TIMEOUT != 0) && !pready && (tcnt == TW'(TIMEOUT - 1));
  assign done = (state == S_ACCESS) && (pready || tmo);

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (win_found) state_nxt = S_SETUP;
      S_SETUP:  state_nxt = S_ACCESS;
      S_ACCESS: if (done) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    psel      = '0;
    penable   = 1'b0;
    if (state == S_IDLE && win_found) req_ready[win_idx] = 1'b1;
    if (state != S_IDLE) psel = 4'b0001 << paddr[31:30];
    if (state == S_ACCESS) penable = 1'b1;
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      ptr       <= IW'(NREQ - 1);
      tcnt      <= '0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      pstrb     <= '0;
      pprot     <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (state == S_IDLE && win_found) begin
        ptr    <= win_idx;
        tcnt   <= '0;
        paddr  <= req_addr[int'(win_idx)*32 +: 32];
        pwrite <= req_write[win_idx];
        pwdata <= req_write[win_idx] ? req_wdata[int'(win_idx)*32 +: 32] : 32'd0;
        pstrb  <= req_write[win_idx] ? req_strb[int'(win_idx)*4 +: 4] : 4'd0;
        pprot  <= req_prot[int'(win_idx)*3 +: 3];
      end
      if (state == S_ACCESS && !pready) tcnt <= tcnt + 1'b1;
      // A timeout completes with an error and no data.
      if (done) begin
        rsp_valid <= NREQ'(1) << ptr;
        rsp_rdata <= (pready && !pwrite) ? prdata : 32'd0;
        rsp_err   <= pready ? pslverr : 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Bench for apb_rr_arbiter: directed scenarios plus randomized traffic.
// Results are compared each cycle with a transfer-level reference model.
module tb_apb_rr_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic               pclk = 1'b0;
  logic               preset = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_addr = '0;
  logic [NREQ-1:0]    req_write = '0;
  logic [NREQ*32-1:0] req_wdata = '0;
  logic [NREQ*4-1:0]  req_strb = '0;
  logic [NREQ*3-1:0]  req_prot = '0;
  logic [NREQ-1:0]    rsp_valid;
  logic [31:0]        rsp_rdata;
  logic               rsp_err;
  logic [31:0]        paddr;
  logic [3:0]         psel;
  logic               penable;
  logic               pwrite;
  logic [31:0]        pwdata;
  logic [3:0]         pstrb;
  logic [2:0]         pprot;
  logic [31:0]        prdata = '0;
  logic               pready = 1'b0;
  logic               pslverr = 1'b0;

  apb_rr_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge pclk) cyc++;

  // Slave model: random ready/error, or a fixed number of wait states.
  int          s_mode = 1;
  int          s_wait = 0;
  logic        s_err = 1'b0;
  logic [31:0] s_rdata = 32'h0;
  int          s_acc = 0;

  always @(posedge pclk) begin
    #1;
    if (penable) s_acc++;
    else         s_acc = 0;
    if (s_mode == 0) begin
      prdata  = $urandom;
      pready  = ($urandom_range(0, 2) == 0);
      pslverr = ($urandom_range(0, 5) == 0);
    end else begin
      prdata  = s_rdata;
      pready  = penable && (s_acc > s_wait);
      pslverr = s_err;
    end
  end

  // Transfer-level reference: phase 0 arbitrate, 1 setup, 2 access.
  int              m_ptr = NREQ - 1;
  int              m_phase = 0;
  int              m_id = 0;
  int              m_acc = 0;
  logic [31:0]     m_addr, m_wdata;
  logic            m_wr;
  logic [3:0]      m_strb;
  logic [2:0]      m_prot;
  bit              m_rsp = 0;
  int              m_rsp_id = 0;
  logic [31:0]     m_rdata = '0;
  logic            m_err = 1'b0;
  logic [NREQ-1:0] m_gnt = '0;
  int              n_done = 0;
  int              n_tmo = 0;

  always @(negedge pclk) begin : model
    int w;
    int j;
    if (!preset) begin
      m_ptr = NREQ - 1; m_phase = 0; m_rsp = 0; m_gnt = '0;
      chk("rst_psel", psel, 0);
      chk("rst_penable", penable, 0);
      chk("rst_paddr", paddr, 0);
      chk("rst_pwdata", {pwrite, pwdata, pstrb, pprot}, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", {rsp_err, rsp_rdata}, 0);
    end else begin
      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (w < 0 && req_valid[j]) w = j;
      end
      m_gnt = (m_phase == 0 && w >= 0) ? NREQ'(1 << w) : '0;
      chk("req_ready", req_ready, m_gnt);
      chk("rsp_valid", rsp_valid, m_rsp ? (1 << m_rsp_id) : 0);
      if (m_rsp) begin
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", rsp_err, m_err);
      end
      if (m_phase == 0) begin
        chk("psel_idle", psel, 0);
        chk("penable_idle", penable, 0);
      end else begin
        chk("psel", psel, 4'b0001 << m_addr[31:30]);
        chk("penable", penable, m_phase == 2);
        chk("paddr", paddr, m_addr);
        chk("pwrite", pwrite, m_wr);
        chk("pwdata", pwdata, m_wr ? m_wdata : 32'd0);
        chk("pstrb", pstrb, m_wr ? m_strb : 4'd0);
        chk("pprot", pprot, m_prot);
      end
      m_rsp = 0;
      case (m_phase)
        0: if (w >= 0) begin
          m_id = w; m_ptr = w;
          m_addr = req_addr[32*w +: 32];
          m_wr = req_write[w];
          m_wdata = req_wdata[32*w +: 32];
          m_strb = req_strb[4*w +: 4];
          m_prot = req_prot[3*w +: 3];
          m_phase = 1;
        end
        1: begin m_phase = 2; m_acc = 0; end
        default: begin
          m_acc++;
          if (pready) begin
            m_rsp = 1; m_rsp_id = m_id; m_phase = 0; n_done++;
            m_rdata = m_wr ? 32'd0 : prdata;
            m_err = pslverr;
          end else if (TIMEOUT > 0 && m_acc >= TIMEOUT) begin
            m_rsp = 1; m_rsp_id = m_id; m_phase = 0; n_done++; n_tmo++;
            m_rdata = 32'd0;
            m_err = 1'b1;
          end
        end
      endcase
    end
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
    req_valid[i] = 1'b1;
    req_addr[32*i +: 32] = a;
    req_write[i] = w;
    req_wdata[32*i +: 32] = d;
    req_strb[4*i +: 4] = s;
    req_prot[3*i +: 3] = p;
  endtask

  task automatic rand_req(input int i);
    set_req(i, $urandom, 1'($urandom), $urandom, 4'($urandom), 3'($urandom));
  endtask

  task automatic wait_grant(input int i, input string tag);
    bit got;
    got = 0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge pclk); #1;
      if (req_ready[i]) got = 1;
    end
    chk(tag, got, 1);
    @(posedge pclk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  int order[$];
  int when[$];
  logic [NREQ-1:0] g;

  initial begin
    idle(3);
    chk("reset_psel", psel, 0);
    preset = 1'b1;
    idle(2);

    // Single write, zero wait states.
    s_mode = 1; s_wait = 0; s_err = 1'b0;
    set_req(0, 32'h0000_0004, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'd0);
    wait_grant(0, "t1_grant");
    idle(5);
    chk("t1_done", n_done, 1);
    chk("t1_rsp", {rsp_err, rsp_rdata}, 0);

    // Read with two wait states.
    s_wait = 2; s_rdata = 32'hCAFE_BABE;
    set_req(1, 32'h4000_0008, 1'b0, 32'h1234_5678, 4'hF, 3'd2);
    wait_grant(1, "t2_grant");
    idle(8);
    chk("t2_rdata", rsp_rdata, 32'hCAFE_BABE);

    // Slave error.
    s_wait = 0; s_err = 1'b1;
    set_req(3, 32'hC000_0000, 1'b0, 32'h0, 4'h0, 3'd1);
    wait_grant(3, "t4_grant");
    idle(5);
    chk("t4_err", rsp_err, 1);

    // Timeout, then a normal transfer.
    s_wait = 1000; s_err = 1'b0;
    set_req(2, 32'h8000_0010, 1'b1, 32'h5555_AAAA, 4'h3, 3'd0);
    wait_grant(2, "t5_grant");
    idle(TIMEOUT + 4);
    chk("t5_tmo", n_tmo, 1);
    chk("t5_err", {rsp_err, rsp_rdata}, 33'h1_0000_0000);
    s_wait = 0; s_rdata = 32'h0BAD_F00D;
    set_req(0, 32'h0000_0020, 1'b0, 32'h0, 4'h0, 3'd0);
    wait_grant(0, "t5_next_grant");
    idle(5);
    chk("t5_next", {rsp_err, rsp_rdata}, {1'b0, 32'h0BAD_F00D});

    // All requesters continuously valid.
    for (int i = 0; i < NREQ; i++) rand_req(i);
    repeat (20) begin
      @(negedge pclk); #1;
      g = req_ready;
      if (g != 0) begin
        order.push_back($clog2(g));
        when.push_back(cyc);
      end
      @(posedge pclk); #1;
      for (int i = 0; i < NREQ; i++) if (g[i]) rand_req(i);
    end
    req_valid = '0;
    chk("rr_count", order.size() >= 6, 1);
    for (int k = 1; k < order.size(); k++) begin
      chk("rr_order", order[k], (order[k-1] + 1) % NREQ);
      chk("rr_gap", when[k] - when[k-1], 3);
    end
    idle(6);

    // Random traffic.
    s_mode = 0;
    repeat (600) begin
      @(negedge pclk); #1;
      g = req_ready;
      @(posedge pclk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (g[i]) begin
          req_valid[i] = 1'b0;
          if ($urandom_range(0, 1) == 0) rand_req(i);
        end else if (!req_valid[i] && $urandom_range(0, 3) == 0) rand_req(i);
        else if (req_valid[i] && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
      end
    end
    req_valid = '0;
    s_mode = 1; s_wait = 0; s_err = 1'b0;
    idle(TIMEOUT + 6);

    // Reset in the middle of ACCESS.
    s_wait = 1000;
    set_req(1, 32'h4000_0100, 1'b1, 32'h1111_2222, 4'hF, 3'd0);
    wait_grant(1, "t6_grant");
    idle(3);
    #2;
    preset = 1'b0;
    #1;
    chk("t6_async_psel", {psel, penable}, 0);
    chk("t6_async_paddr", paddr, 0);
    chk("t6_async_rsp", rsp_valid, 0);
    set_req(2, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 3'd0);
    set_req(0, 32'h0000_0040, 1'b0, 32'h0, 4'h0, 3'd0);
    idle(2);
    s_wait = 0;
    preset = 1'b1;
    @(negedge pclk); #1;
    chk("t6_first", req_ready, 4'b0001);
    wait_grant(0, "t6_grant0");
    wait_grant(2, "t6_grant2");
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/apb_rr_arbiter.md
Name: apb_rr_arbiter

Overview:
- Round-robin arbiter and transfer sequencer sharing one APB master port between NREQ requesters.
- Accepts one request at a time and runs the APB SETUP/ACCESS sequence for it.
- Decodes psel from paddr[31:30], one select per slave (4 slaves).
- Returns read data and error status to the winning requester. Sits between on-chip requesters and the APB slave fabric.

Parameters:
NREQ, 4, number of requesters (2..8)
TIMEOUT, 16, max ACCESS cycles without pready before forced error completion; 0 disables

Ports:
pclk  in  1  clock
preset  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request
req_ready  out  NREQ  one-hot accept; combinational in IDLE
req_addr  in  NREQ*32  packed addresses, requester i at [32i+31:32i]
req_write  in  NREQ  1=write
req_wdata  in  NREQ*32  packed write data
req_strb  in  NREQ*4  packed byte strobes
req_prot  in  NREQ*3  packed protection
rsp_valid  out  NREQ  one-hot completion pulse, registered
rsp_rdata  out  32  read data of completed transfer (0 for writes)
rsp_err  out  1  error of completed transfer, valid with rsp_valid
paddr  out  32  APB address
psel  out  4  one-hot slave select = 1<<paddr[31:30] in SETUP/ACCESS
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  32  APB write data
pstrb  out  4  APB strobes
pprot  out  3  APB protection
prdata  in  32  muxed slave read data
pready  in  1  muxed slave ready
pslverr  in  1  muxed slave error

Behaviour:
- Reset (preset=0, async): all outputs 0; state IDLE; RR pointer = NREQ-1 so requester 0 has top priority; timeout counter 0.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - Winner = first req_valid at or above (pointer+1) mod NREQ.
  - req_ready = one-hot winner, combinational, IDLE only.
  - On the edge: latch winner's addr/write/wdata/strb/prot into bus registers, pointer = winner, go to SETUP.
  - No valid request: stay IDLE, psel=0, penable=0.
- SETUP (exactly 1 cycle): psel one-hot set, penable=0 -> ACCESS.
- ACCESS:
  - psel held, penable=1. All bus outputs stable from SETUP through completion.
  - pready=1: capture prdata (forced 0 if write) and pslverr; pulse rsp_valid[winner] for one cycle on the next cycle; go to IDLE; psel/penable low in that IDLE cycle.
  - pready=0: stay; timeout counter increments.
  - Counter reaches TIMEOUT (TIMEOUT>0): complete with rsp_err=1, rsp_rdata=0; go to IDLE.
  - Counter clears on entry to SETUP.
- Reads: pstrb=0; pwdata=0.
- Throughput: minimum 3 cycles per transfer (IDLE, SETUP, ACCESS).
  - rsp_valid for transfer N coincides with the IDLE arbitration cycle of transfer N+1.
  - A requester may be re-granted in that same cycle if it is the RR winner.
- Requester rules: hold req_valid and fields stable until req_ready; the request is consumed on the req_ready edge. Dropping req_valid before grant is allowed (no grant issued).
- req_ready is never asserted outside IDLE. At most one bit is ever set in req_ready, rsp_valid and psel.
- Pointer wraps NREQ-1 -> 0.
- rsp_rdata and rsp_err hold their last value between pulses.
- Reset mid-transfer: bus is abandoned with no rsp_valid; after release, arbitration restarts from requester 0.

Test Plan:
1. req0 write addr 0x0000_0004, wdata 0xDEADBEEF, strb 0xF; pready=1 in first ACCESS -> SETUP: psel=0001, penable=0; ACCESS: psel=0001, penable=1, pwrite=1; next cycle rsp_valid=0001, rsp_err=0, rsp_rdata=0.
2. req1 read addr 0x4000_0008; slave inserts 2 wait states, then prdata=0xCAFEBABE -> psel=0010, ACCESS lasts 3 cycles, pstrb=0, pwdata=0; rsp_valid=0010, rsp_rdata=0xCAFEBABE.
3. All 4 requesters hold req_valid continuously -> grant order 0,1,2,3,0,1; each req_ready one cycle per round; a new SETUP every 3 cycles.
4. Read addr 0xC000_0000 with pslverr=1, pready=1 -> psel=1000; rsp_err=1 with rsp_valid.
5. pready held 0 -> after 16 ACCESS cycles psel=0, penable=0, rsp_err=1, rsp_rdata=0; next request proceeds normally.
6. preset driven low mid-ACCESS -> all outputs 0 asynchronously, no rsp_valid; after release with req2 and req0 valid, req0 is granted first.
